// File: rtl/fifo_pkg.sv
// Sizing, pointer-wrap and parameter-legality helpers shared by the latch FIFO and its storage words.
package fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-two depths never rely on binary overflow.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic bit params_ok(input int width, input int depth, input int afull_lvl);
    return (width >= 1) && (depth >= 2) && (afull_lvl >= 1) && (afull_lvl <= depth);
  endfunction

endpackage

// File: rtl/latch_word.sv
// One WIDTH-bit storage word: master/slave latch pair that captures d on the rising CLK edge when we is set.
// Latency: q updates at the capturing edge; no backpressure (pure storage).
module latch_word #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic             m_we;
  logic [WIDTH-1:0] m_d;

  // Master follows enable and data through the low phase; only the value settled at the edge is kept.
  always_latch begin
    if (!CLK) begin
      m_we <= we;
      m_d  <= d;
    end
  end

  always_latch begin
    if (CLK && m_we) begin
      q <= m_d;
    end
  end

endmodule

// File: rtl/latch_fifo.sv
// Valid/ready FIFO on latch-pair storage words; a pushed word is visible one edge later, no bypass.
// Backpressure: in_ready = ~full, out_valid = ~empty, both decoded from registered count.
module latch_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        afull
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  if (!params_ok(WIDTH, DEPTH, AFULL_LVL)) begin : g_bad_params
    $error("latch_fifo: illegal WIDTH/DEPTH/AFULL_LVL combination");
  end

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] word_we;
  logic [WIDTH-1:0] word_q [DEPTH];

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign afull     = (count >= CW'(AFULL_LVL));
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= PW'(ptr_next(int'(wr_ptr), DEPTH));
      if (pop)  rd_ptr <= PW'(ptr_next(int'(rd_ptr), DEPTH));
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flush also blocks the storage write so a discarded push leaves no trace.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_we[i] = push & ~flush & (wr_ptr == PW'(i));

    latch_word #(.WIDTH(WIDTH)) u_word (
      .CLK (CLK),
      .we  (word_we[i]),
      .d   (in_data),
      .q   (word_q[i])
    );
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!empty && (rd_ptr == PW'(i))) out_data = word_q[i];
    end
  end

endmodule

// File: tb/tb_latch_fifo.sv
// Directed bench: DEPTH=4/AFULL_LVL=3 instance driven from a vector table plus corner sequences,
// and a DEPTH=3 instance exercising non-power-of-two pointer wrap.
module tb_latch_fifo;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       flush4 = 0, iv4 = 0, or4 = 0;
  logic [7:0] d4 = '0;
  logic       ir4, ov4, full4, empty4, afull4;
  logic [7:0] od4;
  logic [2:0] cnt4;

  logic       flush3 = 0, iv3 = 0, or3 = 0;
  logic [7:0] d3 = '0;
  logic       ir3, ov3, full3, empty3, afull3;
  logic [7:0] od3;
  logic [1:0] cnt3;

  latch_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3)) u_fifo4 (
    .CLK(clk), .nRST(nrst), .flush(flush4), .in_data(d4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(or4), .count(cnt4), .full(full4),
    .empty(empty4), .afull(afull4)
  );

  latch_fifo #(.WIDTH(8), .DEPTH(3)) u_fifo3 (
    .CLK(clk), .nRST(nrst), .flush(flush3), .in_data(d3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3), .count(cnt3), .full(full3),
    .empty(empty3), .afull(afull3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer rule: a stalled word must be held, unchanged, until accepted.
  logic       blk4 = 0;
  logic [7:0] bd4  = '0;
  always @(posedge clk) begin
    if (nrst && blk4 && !flush4 && (!iv4 || d4 !== bd4)) begin
      fails++;
      $display("FAIL protocol4: in_valid/in_data changed while stalled (iv=%0b d=0x%0h held=0x%0h)", iv4, d4, bd4);
    end
    blk4 = nrst && iv4 && !ir4 && !flush4;
    bd4  = d4;
  end

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       rd;
    int         cnt;
    logic       ov;
    logic [7:0] od;
    logic       ir;
    logic       fu;
    logic       af;
  } vec_t;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rd;
  } op_t;

  vec_t       vt[13];
  op_t        ops[14];
  logic [7:0] m3[$];
  logic [7:0] exp_od;
  logic [7:0] popped;
  int         nexp;
  logic       pop_ok, push_ok;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          fl    iv    d      rd   | cnt ov    od     ir    fu    af
    vt[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vt[3]  = '{1'b0, 1'b1, 8'h44, 1'b0, 4, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 8'h55, 1'b0, 4, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b1, 8'h66, 1'b1, 1, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 8'h77, 1'b0, 2, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0};

    ops[0]  = '{1'b1, 8'h01, 1'b0};
    ops[1]  = '{1'b1, 8'h02, 1'b0};
    ops[2]  = '{1'b1, 8'h03, 1'b0};
    ops[3]  = '{1'b0, 8'h00, 1'b1};
    ops[4]  = '{1'b1, 8'h04, 1'b1};
    ops[5]  = '{1'b1, 8'h05, 1'b0};
    ops[6]  = '{1'b0, 8'h00, 1'b1};
    ops[7]  = '{1'b0, 8'h00, 1'b1};
    ops[8]  = '{1'b1, 8'h06, 1'b1};
    ops[9]  = '{1'b1, 8'h07, 1'b0};
    ops[10] = '{1'b0, 8'h00, 1'b1};
    ops[11] = '{1'b0, 8'h00, 1'b1};
    ops[12] = '{1'b0, 8'h00, 1'b1};
    ops[13] = '{1'b0, 8'h00, 1'b1};

    tick();
    tick();
    nrst = 1'b1;
    #2;
    check("rst_count",    32'(cnt4),   0);
    check("rst_empty",    32'(empty4), 1);
    check("rst_full",     32'(full4),  0);
    check("rst_afull",    32'(afull4), 0);
    check("rst_in_ready", 32'(ir4),    1);
    check("rst_out_vld",  32'(ov4),    0);
    check("rst_out_data", 32'(od4),    0);
    check("rst_count3",   32'(cnt3),   0);

    for (int i = 0; i < 13; i++) begin
      flush4 = vt[i].fl;
      iv4    = vt[i].iv;
      d4     = vt[i].d;
      or4    = vt[i].rd;
      #1;
      if (i == 5) check("ir_not_comb", 32'(ir4), 0);
      if (i == 11) begin
        check("no_bypass_vld",  32'(ov4), 0);
        check("no_bypass_data", 32'(od4), 0);
      end
      tick();
      check($sformatf("v%0d_count", i), 32'(cnt4),   32'(vt[i].cnt));
      check($sformatf("v%0d_empty", i), 32'(empty4), 32'(vt[i].cnt == 0));
      check($sformatf("v%0d_ovld", i),  32'(ov4),    32'(vt[i].ov));
      check($sformatf("v%0d_odat", i),  32'(od4),    32'(vt[i].od));
      check($sformatf("v%0d_irdy", i),  32'(ir4),    32'(vt[i].ir));
      check($sformatf("v%0d_full", i),  32'(full4),  32'(vt[i].fu));
      check($sformatf("v%0d_afull", i), 32'(afull4), 32'(vt[i].af));
    end

    // Streaming at count=2: output trails input by two words.
    for (int k = 0; k < 10; k++) begin
      iv4 = 1'b1;
      d4  = 8'(8'h80 + k);
      or4 = 1'b1;
      tick();
      exp_od = (k == 0) ? 8'h77 : 8'(8'h80 + k - 1);
      check($sformatf("stream%0d_count", k), 32'(cnt4), 2);
      check($sformatf("stream%0d_odat", k),  32'(od4),  32'(exp_od));
    end

    iv4 = 1'b1; d4 = 8'h90; or4 = 1'b0;
    tick();
    check("pre_flush_count", 32'(cnt4), 3);

    flush4 = 1'b1; iv4 = 1'b1; d4 = 8'hAA; or4 = 1'b1;
    tick();
    check("flush_count", 32'(cnt4),   0);
    check("flush_empty", 32'(empty4), 1);
    check("flush_ovld",  32'(ov4),    0);
    check("flush_odat",  32'(od4),    0);
    flush4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
    tick();
    check("post_flush_count", 32'(cnt4), 0);
    iv4 = 1'b1; d4 = 8'hBB;
    tick();
    check("post_flush_odat",  32'(od4),  32'h0BB);
    check("post_flush_cnt1",  32'(cnt4), 1);
    d4 = 8'hCC;
    tick();
    d4 = 8'hDD;
    tick();
    iv4 = 1'b0;
    check("pre_reset_count", 32'(cnt4), 3);

    // Asynchronous reset applied away from any clock edge.
    @(negedge clk);
    nrst = 1'b0;
    #1;
    check("async_rst_count", 32'(cnt4),   0);
    check("async_rst_empty", 32'(empty4), 1);
    check("async_rst_ovld",  32'(ov4),    0);
    check("async_rst_odat",  32'(od4),    0);
    check("async_rst_irdy",  32'(ir4),    1);
    tick();
    nrst = 1'b1;
    tick();
    check("after_rst_count", 32'(cnt4), 0);

    nexp = 1;
    for (int i = 0; i < 14; i++) begin
      iv3 = ops[i].iv;
      d3  = ops[i].d;
      or3 = ops[i].rd;
      #1;
      pop_ok  = ops[i].rd && (m3.size() > 0);
      push_ok = ops[i].iv && (m3.size() < 3);
      popped  = od3;
      tick();
      if (pop_ok) begin
        void'(m3.pop_front());
        check($sformatf("d3_pop%0d_order", nexp), 32'(popped), 32'(nexp));
        nexp++;
      end
      if (push_ok) m3.push_back(ops[i].d);
      exp_od = (m3.size() > 0) ? m3[0] : 8'h00;
      check($sformatf("d3_op%0d_count", i), 32'(cnt3),   32'(m3.size()));
      check($sformatf("d3_op%0d_odat", i),  32'(od3),    32'(exp_od));
      check($sformatf("d3_op%0d_full", i),  32'(full3),  32'(m3.size() == 3));
      check($sformatf("d3_op%0d_empty", i), 32'(empty3), 32'(m3.size() == 0));
      check($sformatf("d3_op%0d_afull", i), 32'(afull3), 32'(m3.size() >= 2));
      check($sformatf("d3_op%0d_irdy", i),  32'(ir3),    32'(m3.size() < 3));
      check($sformatf("d3_op%0d_ovld", i),  32'(ov3),    32'(m3.size() > 0));
    end
    check("d3_total_pops", 32'(nexp), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
